seg7_scan_decoder: RTL

//  Reader for the multiplexed 7-segment display bus: samples active-low segment

---
 rtl/seg7_scan_decoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus.
// Rebuilds debounced per-digit BCD and flags illegal codes and anode faults.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STABLE_SCANS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg7,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    err_pattern,
  output logic                    an_err,
  output logic                    frame_done
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] STABLE_MAX = MW'(STABLE_SCANS);

  logic [6:0]                 seg_q;
  logic [NUM_DIGITS-1:0]      an_q, an_prev_q;
  logic [SW-1:0]              settle_q, settle_d;
  logic                       sampled_q, sampled_d;
  logic [NUM_DIGITS-1:0][3:0] cand_q, cand_d;
  logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0][MW-1:0] match_q, match_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic                       err_q, err_d;
  logic                       anerr_q, anerr_d;
  logic                       frame_q, frame_d;

  logic [NUM_DIGITS-1:0] an_low;
  logic                  an_eq;
  logic                  onehot;
  logic                  sample;
  logic [3:0]            dec_val;
  logic                  dec_ok;

  assign an_low      = ~an_q;
  assign an_eq       = (an_q == an_prev_q);
  assign onehot      = $onehot(an_low);
  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign err_pattern = err_q;
  assign an_err      = anerr_q;
  assign frame_done  = frame_q;

  // Dwell tracking: count stable clocks, allow one sample per dwell
  always_comb begin
    settle_d  = '0;
    sampled_d = 1'b0;
    sample    = 1'b0;
    if (an_eq) begin
      settle_d  = (settle_q == SETTLE_MAX) ? settle_q
                                           : settle_q + SW'(1);
      sample    = (settle_d == SETTLE_MAX) && !sampled_q;
      sampled_d = sampled_q | sample;
    end
  end

  // Exact-match segment decoder (gfedcba, active low)
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (seg_q)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Per-digit debounce and error pulse generation on a sample
  always_comb begin
    cand_d  = cand_q;
    match_d = match_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    anerr_d = 1'b0;
    frame_d = 1'b0;
    if (sample && !onehot && an_low != '0) begin
      anerr_d = 1'b1;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sample && onehot && an_low[i]) begin
        frame_d = (i == NUM_DIGITS - 1);
        if (dec_ok) begin
          if (dec_val == cand_q[i]) begin
            match_d[i] = (match_q[i] == STABLE_MAX) ? match_q[i]
                                                    : match_q[i] + MW'(1);
          end else begin
            cand_d[i]  = dec_val;
            match_d[i] = MW'(1);
          end
          if (match_d[i] == STABLE_MAX) begin
            bcd_d[i]   = dec_val;
            valid_d[i] = 1'b1;
          end
        end else begin
          err_d      = 1'b1;
          valid_d[i] = 1'b0;
          match_d[i] = '0;
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= '1;
      an_q      <= '1;
      an_prev_q <= '1;
      settle_q  <= '0;
      sampled_q <= 1'b0;
      cand_q    <= '0;
      match_q   <= '0;
      bcd_q     <= '0;
      valid_q   <= '0;
      err_q     <= 1'b0;
      anerr_q   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      seg_q     <= seg7;
      an_q      <= an;
      an_prev_q <= an_q;
      settle_q  <= settle_d;
      sampled_q <= sampled_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      anerr_q   <= anerr_d;
      frame_q   <= frame_d;
    end
  end

endmodule
